// File: rtl/ame_solver_pkg.sv
// Shared state encoding, data typedefs, default sizes and the round-robin wrap
// helper for the AME solver scheduler.
package ame_solver_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_COMP_DATA_BITS = 64;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int MAT_ROWS           = 6;
    localparam int MAT_COLS           = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_BUSY,
        ST_RESP
    } sched_state_e;

    typedef logic [DEF_COMP_DATA_BITS-1:0] elem_t;
    typedef elem_t [MAT_COLS-1:0]          mat_row_t;
    typedef mat_row_t [MAT_ROWS-1:0]       matrix_t;
    typedef elem_t [MAT_ROWS-1:0]          result_t;

    // (base + off) mod n, for base < n and off < n.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/ame_rr_arbiter.sv
// Round-robin selector: first asserted request at or after the pointer wins.
module ame_rr_arbiter
    import ame_solver_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'(rr_wrap(32'(ptr_i), i, N));
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ame_solver_scheduler.sv
// Shares one ame_equation_solver between NUM_REQ requesters, round-robin.
// Optional BUSY watchdog enabled by defining AME_SOLVER_TIMEOUT_EN.
module ame_solver_scheduler
    import ame_solver_pkg::*;
#(
    parameter int  NUM_REQ        = DEF_NUM_REQ,
    parameter int  COMP_DATA_BITS = DEF_COMP_DATA_BITS,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int MAT_W          = MAT_ROWS * MAT_COLS * COMP_DATA_BITS,
    localparam int RES_W          = MAT_ROWS * COMP_DATA_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0]       req_param6_i,
    input  logic [NUM_REQ*MAT_W-1:0] req_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDX_W-1:0]         rsp_id_o,
    output logic                     rsp_err_o,
    output logic [RES_W-1:0]         rsp_data_o,
    output logic                     slv_init_o,
    output logic                     slv_param6_o,
    output logic [MAT_W-1:0]         slv_data_o,
    input  logic                     slv_done_i,
    input  logic [RES_W-1:0]         slv_data_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic               first_q, first_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               init_q, init_d;
    logic               param6_q, param6_d;
    logic [MAT_W-1:0]   slv_data_q, slv_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

`ifdef AME_SOLVER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    ame_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        first_d     = first_q;
        ready_d     = '0;
        init_d      = 1'b0;
        param6_d    = param6_q;
        slv_data_d  = slv_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef AME_SOLVER_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    ready_d    = arb_gnt;
                    grant_id_d = arb_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            slv_data_d = req_data_i[i*MAT_W +: MAT_W];
                            param6_d   = req_param6_i[i];
                        end
                    end
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                init_d  = 1'b1;
                first_d = 1'b1;
`ifdef AME_SOLVER_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                first_d = 1'b0;
                // The done level seen alongside the launch pulse belongs to the previous job.
                if (!first_q && slv_done_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_id_q;
                    rsp_data_d  = slv_data_i;
`ifdef AME_SOLVER_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_id_q;
                    rsp_data_d  = '0;
                    err_d       = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_d        = wd_q + 1'b1;
`endif
                end
                if (!first_q && slv_done_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments only; all blocking math stays in always_comb.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            first_q     <= 1'b0;
            ready_q     <= '0;
            init_q      <= 1'b0;
            param6_q    <= 1'b0;
            // NOTE: wide data registers are reset only because they drive ports that must read 0.
            slv_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef AME_SOLVER_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            first_q     <= first_d;
            ready_q     <= ready_d;
            init_q      <= init_d;
            param6_q    <= param6_d;
            slv_data_q  <= slv_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef AME_SOLVER_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready_o  = ready_q;
    assign slv_init_o   = init_q;
    assign slv_param6_o = param6_q;
    assign slv_data_o   = slv_data_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;

endmodule

// File: tb/tb_ame_solver_scheduler.sv
// Randomized bench for ame_solver_scheduler with a round-robin service model
// and a behavioural solver that keeps its done level high between jobs.
module tb_ame_solver_scheduler;

    localparam int N     = 4;
    localparam int CDB   = 8;
    localparam int MAT_W = 42 * CDB;
    localparam int RES_W = 6 * CDB;
    localparam int TMO   = 16;
`ifdef AME_SOLVER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [N-1:0]         req_param6_i;
    logic [N*MAT_W-1:0]   req_data_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [1:0]           rsp_id_o;
    logic                 rsp_err_o;
    logic [RES_W-1:0]     rsp_data_o;
    logic                 slv_init_o;
    logic                 slv_param6_o;
    logic [MAT_W-1:0]     slv_data_o;
    logic                 slv_done_i;
    logic [RES_W-1:0]     slv_data_i;

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;

    always #5 clk_i = ~clk_i;

    ame_solver_scheduler #(
        .NUM_REQ        (N),
        .COMP_DATA_BITS (CDB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_param6_i (req_param6_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_data_o   (rsp_data_o),
        .slv_init_o   (slv_init_o),
        .slv_param6_o (slv_param6_o),
        .slv_data_o   (slv_data_o),
        .slv_done_i   (slv_done_i),
        .slv_data_i   (slv_data_i)
    );

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next requester to serve: first valid one at or after the fairness pointer.
    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready_o, '0);
        check({tag, "_rsp_valid"}, rsp_valid_o, '0);
        check({tag, "_rsp_id"}, rsp_id_o, '0);
        check({tag, "_rsp_err"}, rsp_err_o, '0);
        check({tag, "_rsp_data"}, rsp_data_o, '0);
        check({tag, "_slv_init"}, slv_init_o, '0);
        check({tag, "_slv_param6"}, slv_param6_o, '0);
        check({tag, "_slv_data"}, slv_data_o, '0);
    endtask

    // One job: present requests, follow grant/launch, act as the solver
    // (done rises at busy cycle lat), then hold the response dly cycles.
    task automatic run_job(input logic [N-1:0] valid, input int lat, input int dly,
                           input int abort_at);
        int               g;
        int               k;
        bit               got_rsp;
        bit               err;
        logic [RES_W-1:0] res;
        logic [RES_W-1:0] exp_data;
        for (int w = 0; w < N * MAT_W / 32; w++) req_data_i[w*32 +: 32] = $urandom();
        req_param6_i = N'($urandom());
        res          = RES_W'({$urandom(), $urandom()});
        req_valid_i  = valid;
        g            = exp_grant(valid, exp_ptr);

        @(negedge clk_i);
        check("grant_onehot", req_ready_o, N'(1) << g);
        check("init_before_launch", slv_init_o, 1'b0);
        @(negedge clk_i);
        check("launch_init", slv_init_o, 1'b1);
        check("ready_single_pulse", req_ready_o, '0);
        check("launch_matrix", slv_data_o, req_data_i[g*MAT_W +: MAT_W]);
        check("launch_param6", slv_param6_o, req_param6_i[g]);

        slv_data_i = res;
        got_rsp    = 1'b0;
        err        = 1'b0;
        k          = 1;
        while (!got_rsp) begin
            bit acc;
            bit tmo;
            if (k > 1) slv_done_i = (k >= lat);
            acc = (k >= 2) && slv_done_i;
            tmo = TMO_EN && !acc && (k == TMO);
            if (k == abort_at) begin
                rst_i = 1'b1;
                @(negedge clk_i);
                check_all_zero("mid_reset");
                req_valid_i = '0;
                rst_i       = 1'b0;
                exp_ptr     = 0;
                return;
            end
            @(negedge clk_i);
            check("busy_rsp_valid", rsp_valid_o, acc || tmo);
            check("busy_no_init", slv_init_o, 1'b0);
            if (acc || tmo) begin
                got_rsp = 1'b1;
                err     = tmo;
            end else if (k >= 300) begin
                checks++;
                errors++;
                $display("FAIL busy_bound: no response after %0d busy cycles", k);
                return;
            end
            k++;
        end

        exp_data = err ? '0 : res;
        for (int c = 0; c <= dly; c++) begin
            check("rsp_valid", rsp_valid_o, 1'b1);
            check("rsp_id", rsp_id_o, g);
            check("rsp_data", rsp_data_o, exp_data);
            check("rsp_err", rsp_err_o, err);
            check("resp_no_grant", req_ready_o, '0);
            check("resp_no_init", slv_init_o, 1'b0);
            if (c < dly) @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check("rsp_released", rsp_valid_o, 1'b0);
        exp_ptr = (g + 1) % N;
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = '0;
        req_param6_i = '0;
        req_data_i   = '0;
        rsp_ready_i  = 1'b0;
        slv_done_i   = 1'b0;
        slv_data_i   = '0;
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        // All requesters held: service order 0,1,2,3,0.
        for (int j = 0; j < 5; j++) run_job(4'b1111, 3, 0, 0);

        // Lone requester 2; done is still high from the previous job (stale level).
        run_job(4'b0100, 2, 0, 0);

        // Consumer stalls 10 cycles.
        run_job(4'b1001, 4, 10, 0);

        // Idle with no requests and a stale done level: nothing moves.
        req_valid_i = '0;
        slv_done_i  = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("idle_no_grant", req_ready_o, '0);
            check("idle_no_rsp", rsp_valid_o, 1'b0);
        end

        for (int j = 0; j < 20; j++) begin
            run_job(N'($urandom_range(1, 15)), $urandom_range(2, 6), $urandom_range(0, 3), 0);
        end

        // Reset while busy, then a late done must not produce a response.
        run_job(4'b1010, 50, 0, 3);
        slv_done_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check("post_reset_no_rsp", rsp_valid_o, 1'b0);
            check("post_reset_no_grant", req_ready_o, '0);
        end
        run_job(4'b1010, 2, 1, 0);

`ifdef AME_SOLVER_TIMEOUT_EN
        run_job(4'b0001, 100000, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ame_solver_scheduler.md
AME_SOLVER_SCHEDULER -- requirements
Module: ame_solver_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one ame_equation_solver.
REQ-002 SHALL have parameter COMP_DATA_BITS, default 64: matrix/result element width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in BUSY.
REQ-004 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, NUM_REQ: per-requester request pending.
REQ-007 SHALL have port req_ready_o, output, NUM_REQ: one-hot accept pulse to the granted requester.
REQ-008 SHALL have port req_param6_i, input, NUM_REQ: per-requester 6-parameter (1) / 4-parameter (0) mode.
REQ-009 SHALL have port req_data_i, input, NUM_REQ x 6x7xCOMP_DATA_BITS: per-requester augmented matrix.
REQ-010 SHALL have port rsp_valid_o, input-to-consumer output, 1: result valid.
REQ-011 SHALL have port rsp_ready_i, input, 1: consumer accepts result.
REQ-012 SHALL have port rsp_id_o, output, clog2(NUM_REQ): index of the requester owning the result.
REQ-013 SHALL have port rsp_err_o, output, 1: result aborted by watchdog.
REQ-014 SHALL have port rsp_data_o, output, 6xCOMP_DATA_BITS: solved X0..X5 fixed point.
REQ-015 SHALL have ports slv_init_o (out, 1), slv_param6_o (out, 1), slv_data_o (out, 6x7xCOMP_DATA_BITS): solver launch, mode, matrix.
REQ-016 SHALL have ports slv_done_i (in, 1) and slv_data_i (in, 6xCOMP_DATA_BITS): solver completion level and results.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, BUSY, RESP.
REQ-018 IDLE: when any req_valid_i bit set, SHALL grant round-robin starting at pointer, pulse req_ready_o[grant] one cycle, capture req_data_i[grant], req_param6_i[grant], grant index; next LAUNCH.
REQ-019 No request in IDLE: req_ready_o SHALL be 0, state stays IDLE, pointer unchanged.
REQ-020 LAUNCH: slv_init_o SHALL be 1 for exactly one cycle; next BUSY; watchdog counter cleared to 0.
REQ-021 slv_data_o and slv_param6_o SHALL hold captured values from LAUNCH until next capture.
REQ-022 BUSY: slv_done_i SHALL be ignored in the first BUSY cycle (solver done level may be stale); from second BUSY cycle, slv_done_i=1 SHALL register slv_data_i into rsp_data_o, rsp_err_o=0, next RESP.
REQ-023 RESP: rsp_valid_o SHALL be 1 with rsp_id_o, rsp_data_o, rsp_err_o stable until rsp_ready_i=1; on handshake next IDLE, pointer = (grant+1) mod NUM_REQ.
REQ-024 Requests arriving during LAUNCH/BUSY/RESP SHALL wait; no requester SHALL be granted twice while another valid requester waits (fairness bound NUM_REQ services).
REQ-025 Minimum turnaround IDLE->IDLE SHALL be solver latency + 3 cycles with rsp_ready_i held 1.
REQ-026 slv_done_i asserted in IDLE, LAUNCH or RESP SHALL be ignored.

Reset
REQ-027 rst_i=1 SHALL force state IDLE, pointer 0, and all outputs 0 (req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o, slv_init_o, slv_param6_o, slv_data_o) on the next edge.
REQ-028 Reset mid-operation SHALL drop the in-flight job without response; later solver done SHALL be ignored per REQ-026.

Configuration
REQ-029 With AME_SOLVER_TIMEOUT_EN defined, BUSY SHALL count cycles; reaching TIMEOUT_CYCLES without done SHALL go RESP with rsp_err_o=1, rsp_data_o=0.
REQ-030 Without AME_SOLVER_TIMEOUT_EN, no counter SHALL exist, BUSY waits indefinitely, rsp_err_o tied 0.

Structure
REQ-031 State enum, element/matrix typedefs and default parameter constants SHALL live in package ame_solver_pkg.
REQ-032 Round-robin selection SHALL be sub-module ame_rr_arbiter (req vector + pointer -> one-hot grant, index, any).

Verification
REQ-033 Single req_valid_i=4'b0100 -> req_ready_o=4'b0100 one cycle, slv_init_o one cycle later, rsp_id_o=2 with solver outputs after done.
REQ-034 req_valid_i=4'b1111 held -> grant order 0,1,2,3,0 across five jobs.
REQ-035 slv_done_i held 1 from previous job -> not accepted in first BUSY cycle; accepted second cycle.
REQ-036 rsp_ready_i=0 for 10 cycles in RESP -> rsp outputs stable, no new grant, no slv_init_o.
REQ-037 rst_i=1 mid-BUSY -> all outputs 0 next cycle; subsequent slv_done_i=1 yields no rsp_valid_o.
REQ-038 AME_SOLVER_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> rsp_valid_o with rsp_err_o=1, rsp_data_o=0 after 16 BUSY cycles.
